// File: rtl/hex_display_ctrl_pkg.sv
// hex_pkg: shared types and constants for the hex display controller.
//   state_t        FSM states (IDLE, SHIFT, LOAD)
//   BCD_DIGITS     number of BCD nibbles kept by the double-dabble shifter
//   SEG_BLANK      all segments off (active-low)
//   SEG_GLYPH      active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   dabble_adjust  add-3 correction applied to every nibble >= 5
package hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 10;
  localparam int BCD_BITS   = BCD_DIGITS * 4;
  localparam int NUM_HEX    = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_GLYPH [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [BCD_BITS-1:0] dabble_adjust(input logic [BCD_BITS-1:0] bcd);
    logic [BCD_BITS-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational BCD digit to active-low seven-segment pattern.
//   digit  in   4  BCD digit (10..15 show blank)
//   blank  in   1  force all segments off
//   seg    out  7  active-low {g,f,e,d,c,b,a}
module hex_seg_decode
  import hex_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_GLYPH[digit];
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: converts a CPU-written binary value to decimal with a
// sequential double-dabble shifter and drives eight seven-segment displays.
//
// Ports:
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous active-low reset
//   wr_en        in   1          one-cycle write strobe
//   wr_data      in   CONV_BITS  unsigned value to display
//   busy         out  1          conversion running or pending
//   ovf          out  1          last displayed value exceeded 8 decimal digits
//   HEX0..HEX7   out  7 each     active-low segments, HEX0 least significant
//
// Build option: define HEX_LZB_EN for leading-zero blanking on HEX7..HEX1.
//
// state | meaning
// IDLE  | no conversion running; accepts a write or the pending value
// SHIFT | double-dabble shifting, one bit per cycle
// LOAD  | segment patterns and ovf registered to the outputs
module hex_display_ctrl
  import hex_pkg::*;
#(
  parameter int CONV_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [CONV_BITS-1:0] wr_data,
  output logic                 busy,
  output logic                 ovf,
  output logic [6:0]           HEX0,
  output logic [6:0]           HEX1,
  output logic [6:0]           HEX2,
  output logic [6:0]           HEX3,
  output logic [6:0]           HEX4,
  output logic [6:0]           HEX5,
  output logic [6:0]           HEX6,
  output logic [6:0]           HEX7
);

  localparam int SR_W  = BCD_BITS + CONV_BITS;
  localparam int CNT_W = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_BITS - 1);

`ifdef HEX_LZB_EN
  localparam logic [6:0] HEX_RST_HI = SEG_BLANK;
`else
  localparam logic [6:0] HEX_RST_HI = SEG_GLYPH[0];
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [CONV_BITS-1:0] pend_data_q, pend_data_d;
  logic                 ovf_q, ovf_d;
  logic [6:0]           hex_q [NUM_HEX];
  logic [6:0]           hex_d [NUM_HEX];

  logic [BCD_BITS-1:0]  bcd;
  logic [SR_W-1:0]      sr_adj;
  logic [NUM_HEX-1:0]   blank;
  logic [6:0]           seg_w [NUM_HEX];

  assign bcd = sr_q[CONV_BITS +: BCD_BITS];

  // Blank every digit above the most-significant nonzero one; HEX0 always lit.
  always_comb begin
    blank = '0;
`ifdef HEX_LZB_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = NUM_HEX - 1; i >= 1; i--) begin
        seen     = seen | (bcd[4*i +: 4] != 4'd0);
        blank[i] = ~seen;
      end
    end
`endif
  end

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_dec
    hex_seg_decode u_dec (
      .digit (bcd[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_w[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    ovf_d        = ovf_q;
    sr_adj       = {dabble_adjust(bcd), sr_q[CONV_BITS-1:0]};
    for (int i = 0; i < NUM_HEX; i++) begin
      hex_d[i] = hex_q[i];
    end

    case (state_q)
      IDLE: begin
        // A fresh write supersedes anything still pending.
        if (wr_en) begin
          sr_d         = {{BCD_BITS{1'b0}}, wr_data};
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          state_d      = SHIFT;
        end else if (pend_valid_q) begin
          sr_d         = {{BCD_BITS{1'b0}}, pend_data_q};
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int i = 0; i < NUM_HEX; i++) begin
          hex_d[i] = seg_w[i];
        end
        ovf_d   = |bcd[BCD_BITS-1 -: 8];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Writes arriving mid-conversion go to a one-deep buffer, last one wins.
    if (wr_en && (state_q != IDLE)) begin
      pend_data_d  = wr_data;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      ovf_q        <= 1'b0;
      hex_q[0]     <= SEG_GLYPH[0];
      for (int i = 1; i < NUM_HEX; i++) begin
        hex_q[i] <= HEX_RST_HI;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      ovf_q        <= ovf_d;
      for (int i = 0; i < NUM_HEX; i++) begin
        hex_q[i] <= hex_d[i];
      end
    end
  end

  assign busy = (state_q != IDLE) | pend_valid_q;
  assign ovf  = ovf_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule
